prbs_checker: RTL and testbench
===============================

Name: prbs_checker

Overview:
- Downstream consumer of the PRBS9 generator (x^9 + x^5 + 1) in the DSP chain.
- Takes the recovered bit stream after the channel/slicer and aligns a local PRBS9 copy to it by loading the local register from received bits.
- Once locked, compares every valid bit against the prediction and accumulates bit and error counts for BER measurement.

Parameters:
- LOCK_N, 16: consecutive matching bits required in VERIFY before declaring lock.
- WIN_LEN, 128: length in valid bits of the loss-of-lock observation window.
- LOSS_TH, 8: error count within one window that forces relock; lock is lost when errors exceed LOSS_TH.
- CNT_W, 32: width of the bit and error counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- enable  in  1  bit_in valid strobe; all state advances only when enable=1.
- bit_in  in  1  received bit.
- clear  in  1  synchronous counter clear; does not affect lock state.
- locked  out  1  1 while in LOCKED.
- bit_count  out  CNT_W  valid bits checked while LOCKED; saturating.
- err_count  out  CNT_W  mismatches while LOCKED; saturating.

Behaviour:
- Reset (rst=0, async): state=SEARCH, fill counter=0, local LFSR=0, match counter=0, window counters=0, locked=0, bit_count=0, err_count=0.
- Recursion:
  - Sequence obeys s[n+9] = s[n] ^ s[n+4].
  - Local register L[8:0] holds s[n..n+8] with L[0]=s[n], the predicted bit.
  - Advance: L <= {L[0]^L[4], L[8:1]}.
- SEARCH:
  - Each valid bit shifts in at the top: L <= {bit_in, L[8:1]}.
  - The fill counter increments per valid bit.
  - After the 9th valid bit, go to VERIFY. L now holds the last 9 received bits; the next expected bit is L[0]^L[4] after one more advance.
  - Implementation detail: in VERIFY/LOCKED, compare bit_in against pred = L[0]^L[4], then shift pred in (L <= {pred, L[8:1]}).
  - The local register never takes received bits outside SEARCH.
- VERIFY:
  - Per valid bit: if bit_in == pred, the match counter increments; else go to SEARCH with fill counter=0.
  - When the match counter reaches LOCK_N, go to LOCKED on that same edge.
  - Window counters are zeroed on entering LOCKED.
- LOCKED:
  - locked=1, registered; it rises on the edge that enters LOCKED.
  - Per valid bit: bit_count+1; err_count+1 on mismatch. Both hold at all-ones (2^CNT_W-1).
  - Window counters: win_bits and win_errs. win_errs increments on mismatch.
  - If win_errs would exceed LOSS_TH, go to SEARCH: locked=0 next cycle, fill=0. The erroring bit is still counted.
  - When win_bits reaches WIN_LEN-1 on a valid bit, both window counters restart at 0 on the next bit.
- Latency: with an error-free aligned stream from reset, locked=1 after the edge of valid bit number 9+LOCK_N (25 by default). Gaps in enable only stretch this.
- clear:
  - Zeroes bit_count and err_count.
  - clear and enable in the same cycle: clear wins; that bit is not counted, but it still advances L and the window/state logic.
- The all-zero stream (generator seeded 0) locks with L=0 and counts zero errors. This is legal and intended.
- Outputs are registered; there is no combinational path from bit_in to any output.

Decomposition:
- Shared package prbs_pkg:
  - PRBS9 length 9.
  - Tap indices 0 and 4.
  - State encoding SEARCH/VERIFY/LOCKED (2 bits).
- Sub-module prbs_lfsr_load: 9-bit LFSR with enable, load-shift (serial seed) and advance modes, exposing pred. The checker FSM and counters stay in prbs_checker.

Test Plan:
- Generator seed 9'h1FF, enable=1 continuous, stream fed directly (first 9 bits all 1, bit 10 = 0) -> locked rises after bit 25; after 1000 further bits, bit_count=1000, err_count=0.
- Same stream, single bit flipped at locked bit 100 -> err_count=1, locked stays 1, bit_count keeps counting.
- Flip bit 3 of the VERIFY phase -> return to SEARCH; lock is reached 9+16 valid bits after that error; counters stay 0.
- Once locked, inject 9 errors within 20 bits -> locked=0 one cycle after the 9th error, err_count=9, relock 25 valid bits later.
- enable toggling 1/0 every cycle -> lock after 25 valid bits (about 50 cycles); counts increment only on enable=1.
- Assert rst=0 mid-LOCKED with the clock stopped -> outputs go to 0 immediately. Assert clear with enable=1 -> counters read 0 the next cycle. CNT_W=4 with continuous errors -> err_count saturates at 15.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS9 (x^9 + x^5 + 1) checker.
// Holds the register length, the two feedback tap positions and the
// checker state encoding.
package prbs_pkg;

    localparam int PRBS_LEN = 9;
    localparam int TAP_A    = 0;
    localparam int TAP_B    = 4;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

endpackage

// File: rtl/prbs_checker_if.sv
// Bit-stream side of the PRBS checker.
//   enable    : bit_in valid strobe
//   bit_in    : received bit
//   clear     : synchronous counter clear
//   locked    : checker is aligned to the stream
//   bit_count : bits checked while locked (saturating)
//   err_count : mismatches while locked (saturating)
// master drives the stream and reads results; slave is the checker.
interface prbs_checker_if #(parameter int CNT_W = 32);

    logic             enable;
    logic             bit_in;
    logic             clear;
    logic             locked;
    logic [CNT_W-1:0] bit_count;
    logic [CNT_W-1:0] err_count;

    modport master (
        output enable, bit_in, clear,
        input  locked, bit_count, err_count
    );

    modport slave (
        input  enable, bit_in, clear,
        output locked, bit_count, err_count
    );

endinterface

// File: rtl/prbs_lfsr_load.sv
// 9-bit PRBS9 register that can either be seeded serially from received
// bits (load) or run freely on its own recursion (advance).
//   clk, rst : clock, asynchronous active-low reset
//   en_i     : step the register this cycle
//   load_i   : 1 = shift din_i in at the top, 0 = shift the prediction in
//   din_i    : serial seed bit
//   pred_o   : next expected stream bit
module prbs_lfsr_load
    import prbs_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic load_i,
    input  logic din_i,
    output logic pred_o
);

    logic [PRBS_LEN-1:0] lfsr_q;
    logic [PRBS_LEN-1:0] lfsr_d;

    // lfsr_q[0] is the oldest bit s[n]; s[n+9] = s[n] ^ s[n+4].
    assign pred_o = lfsr_q[TAP_A] ^ lfsr_q[TAP_B];

    // Both modes shift right; only the bit entering at the top differs.
    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) begin
            if (load_i) begin
                lfsr_d = {din_i, lfsr_q[PRBS_LEN-1:1]};
            end else begin
                lfsr_d = {pred_o, lfsr_q[PRBS_LEN-1:1]};
            end
        end
    end

    // Register update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// PRBS9 checker: aligns a local PRBS9 copy to the received stream, verifies
// the alignment, then counts checked bits and errors for BER measurement.
// Lock is dropped when too many errors land inside one observation window.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : stream and result signals (prbs_checker_if.slave)
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_N  = 16,
    parameter int WIN_LEN = 128,
    parameter int LOSS_TH = 8,
    parameter int CNT_W   = 32
) (
    input  logic           clk,
    input  logic           rst,
    prbs_checker_if.slave  bus
);

    localparam int FILL_W  = $clog2(PRBS_LEN);
    localparam int MATCH_W = $clog2(LOCK_N + 1);
    localparam int WBIT_W  = $clog2(WIN_LEN + 1);
    localparam int WERR_W  = $clog2(WIN_LEN + LOSS_TH + 2);

    state_e             state_q,    state_d;
    logic [FILL_W-1:0]  fillCnt_q,  fillCnt_d;
    logic [MATCH_W-1:0] matchCnt_q, matchCnt_d;
    logic [WBIT_W-1:0]  winBits_q,  winBits_d;
    logic [WERR_W-1:0]  winErrs_q,  winErrs_d;
    logic [CNT_W-1:0]   bitCnt_q,   bitCnt_d;
    logic [CNT_W-1:0]   errCnt_q,   errCnt_d;

    logic              pred;
    logic              mismatch;
    logic              loadLfsr;
    logic [WERR_W-1:0] winErrsNext;

    // The local register takes received bits only while searching.
    assign loadLfsr = (state_q == SEARCH);

    prbs_lfsr_load uLfsr (
        .clk    (clk),
        .rst    (rst),
        .en_i   (bus.enable),
        .load_i (loadLfsr),
        .din_i  (bus.bit_in),
        .pred_o (pred)
    );

    assign mismatch    = bus.bit_in ^ pred;
    assign winErrsNext = winErrs_q + WERR_W'(mismatch);

    // Next-state and counter logic; everything advances only on valid bits,
    // except clear, which zeroes the result counters unconditionally.
    always_comb begin
        state_d    = state_q;
        fillCnt_d  = fillCnt_q;
        matchCnt_d = matchCnt_q;
        winBits_d  = winBits_q;
        winErrs_d  = winErrs_q;
        bitCnt_d   = bitCnt_q;
        errCnt_d   = errCnt_q;

        if (bus.enable) begin
            case (state_q)
                SEARCH: begin
                    if (fillCnt_q == FILL_W'(PRBS_LEN - 1)) begin
                        state_d    = VERIFY;
                        fillCnt_d  = '0;
                        matchCnt_d = '0;
                    end else begin
                        fillCnt_d = fillCnt_q + 1'b1;
                    end
                end
                VERIFY: begin
                    if (mismatch) begin
                        state_d   = SEARCH;
                        fillCnt_d = '0;
                    end else begin
                        matchCnt_d = matchCnt_q + 1'b1;
                        if (matchCnt_d == MATCH_W'(LOCK_N)) begin
                            state_d   = LOCKED;
                            winBits_d = '0;
                            winErrs_d = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (bitCnt_q != '1) begin
                        bitCnt_d = bitCnt_q + 1'b1;
                    end
                    if (mismatch && (errCnt_q != '1)) begin
                        errCnt_d = errCnt_q + 1'b1;
                    end
                    // The offending bit is still counted above.
                    if (winErrsNext > WERR_W'(LOSS_TH)) begin
                        state_d   = SEARCH;
                        fillCnt_d = '0;
                    end
                    if (winBits_q == WBIT_W'(WIN_LEN - 1)) begin
                        winBits_d = '0;
                        winErrs_d = '0;
                    end else begin
                        winBits_d = winBits_q + 1'b1;
                        winErrs_d = winErrsNext;
                    end
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
        end

        if (bus.clear) begin
            bitCnt_d = '0;
            errCnt_d = '0;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= SEARCH;
            fillCnt_q  <= '0;
            matchCnt_q <= '0;
            winBits_q  <= '0;
            winErrs_q  <= '0;
            bitCnt_q   <= '0;
            errCnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            fillCnt_q  <= fillCnt_d;
            matchCnt_q <= matchCnt_d;
            winBits_q  <= winBits_d;
            winErrs_q  <= winErrs_d;
            bitCnt_q   <= bitCnt_d;
            errCnt_q   <= errCnt_d;
        end
    end

    assign bus.locked    = (state_q == LOCKED);
    assign bus.bit_count = bitCnt_q;
    assign bus.err_count = errCnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker. A PRBS9 generator model seeded 9'h1FF
// produces the reference stream; errors are injected by flipping bits.
// A second instance with 4-bit counters and a high loss threshold sees the
// inverted stream once locked, to exercise counter saturation.
module tb_prbs_checker;

    logic       clk = 1'b0;
    logic       rst;
    bit         clkRun = 1'b1;
    logic       smallInvert;
    logic [8:0] gen;
    int         totalChecks = 0;
    int         badChecks = 0;

    prbs_checker_if #(.CNT_W(32)) bus ();
    prbs_checker_if #(.CNT_W(4))  busSmall ();

    prbs_checker #(.LOCK_N(16), .WIN_LEN(128), .LOSS_TH(8), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    prbs_checker #(.LOCK_N(16), .WIN_LEN(128), .LOSS_TH(128), .CNT_W(4)) dutSmall (
        .clk (clk),
        .rst (rst),
        .bus (busSmall)
    );

    assign busSmall.enable = bus.enable;
    assign busSmall.clear  = bus.clear;
    assign busSmall.bit_in = bus.bit_in ^ smallInvert;

    // Free-running clock that can be frozen for the async reset check.
    always #5 if (clkRun) clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock cycle of stimulus. Disabled cycles drive the wrong bit so
    // that any state change on them shows up as an error.
    task automatic applyStimulus(input bit en, input bit flip, input bit clr);
        bus.enable = en;
        bus.clear  = clr;
        bus.bit_in = en ? (gen[0] ^ flip) : ~gen[0];
        @(posedge clk);
        #1;
        if (en) gen = {gen[0] ^ gen[4], gen[8:1]};
    endtask

    task automatic runBits(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        rst = 1'b0;
        gen = 9'h1FF;
        #1;
        checkOutput("rst_locked", 32'(bus.locked), 32'd0);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst         = 1'b0;
        smallInvert = 1'b0;
        gen         = 9'h1FF;
        bus.enable  = 1'b0;
        bus.bit_in  = 1'b0;
        bus.clear   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("init_locked", 32'(bus.locked), 32'd0);
        checkOutput("init_bits", bus.bit_count, 32'd0);
        checkOutput("init_errs", bus.err_count, 32'd0);
        rst = 1'b1;

        // Clean stream: lock exactly on valid bit 25.
        runBits(24);
        checkOutput("lock_bit24", 32'(bus.locked), 32'd0);
        runBits(1);
        checkOutput("lock_bit25", 32'(bus.locked), 32'd1);
        checkOutput("lock_bits0", bus.bit_count, 32'd0);
        checkOutput("small_lock", 32'(busSmall.locked), 32'd1);

        smallInvert = 1'b1;
        runBits(1000);
        smallInvert = 1'b0;
        checkOutput("clean_bits", bus.bit_count, 32'd1000);
        checkOutput("clean_errs", bus.err_count, 32'd0);
        checkOutput("clean_locked", 32'(bus.locked), 32'd1);
        checkOutput("sat_bits", 32'(busSmall.bit_count), 32'd15);
        checkOutput("sat_errs", 32'(busSmall.err_count), 32'd15);
        checkOutput("sat_locked", 32'(busSmall.locked), 32'd1);

        // clear with enable: clear wins, bit not counted.
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("clr_bits", bus.bit_count, 32'd0);
        checkOutput("clr_errs", bus.err_count, 32'd0);

        // Single error at locked bit 100.
        runBits(99);
        applyStimulus(1'b1, 1'b1, 1'b0);
        runBits(50);
        checkOutput("one_err_errs", bus.err_count, 32'd1);
        checkOutput("one_err_bits", bus.bit_count, 32'd150);
        checkOutput("one_err_locked", 32'(bus.locked), 32'd1);

        // Async reset while the clock is frozen.
        clkRun = 1'b0;
        #20;
        rst = 1'b0;
        #1;
        checkOutput("frz_locked", 32'(bus.locked), 32'd0);
        checkOutput("frz_bits", bus.bit_count, 32'd0);
        checkOutput("frz_errs", bus.err_count, 32'd0);
        #10;
        gen = 9'h1FF;
        rst = 1'b1;
        #3;
        clkRun = 1'b1;

        // Loss of lock: 9 errors on alternating bits, fresh window.
        runBits(25);
        checkOutput("relock_rst", 32'(bus.locked), 32'd1);
        runBits(5);
        for (int i = 0; i <= 16; i++) begin
            applyStimulus(1'b1, (i % 2) == 0, 1'b0);
            if (i == 14) checkOutput("lock_8err", 32'(bus.locked), 32'd1);
        end
        checkOutput("loss_locked", 32'(bus.locked), 32'd0);
        checkOutput("loss_errs", bus.err_count, 32'd9);
        checkOutput("loss_bits", bus.bit_count, 32'd22);
        runBits(24);
        checkOutput("loss_relock24", 32'(bus.locked), 32'd0);
        runBits(1);
        checkOutput("loss_relock25", 32'(bus.locked), 32'd1);
        checkOutput("loss_bits_hold", bus.bit_count, 32'd22);

        // Error on the third VERIFY bit (stream bit 12).
        doReset();
        for (int b = 1; b <= 25; b++) applyStimulus(1'b1, b == 12, 1'b0);
        checkOutput("verr_bit25", 32'(bus.locked), 32'd0);
        runBits(11);
        checkOutput("verr_bit36", 32'(bus.locked), 32'd0);
        runBits(1);
        checkOutput("verr_bit37", 32'(bus.locked), 32'd1);
        checkOutput("verr_bits", bus.bit_count, 32'd0);
        checkOutput("verr_errs", bus.err_count, 32'd0);

        // Enable toggling every cycle.
        doReset();
        for (int k = 0; k < 24; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            applyStimulus(1'b0, 1'b0, 1'b0);
        end
        checkOutput("tog_valid24", 32'(bus.locked), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("tog_valid25", 32'(bus.locked), 32'd1);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            applyStimulus(1'b1, 1'b0, 1'b0);
        end
        checkOutput("tog_bits", bus.bit_count, 32'd10);
        checkOutput("tog_errs", bus.err_count, 32'd0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
